// File: rtl/prbs7_chk.sv
// Serial checker for the XNOR PRBS7 pattern (x^7 + x^6 + 1): self-synchronises, then free-runs and counts bit errors.
// Optional build macro PRBS7_CHK_INV_EN adds a static 'inv' input for checking an inverted stream.
module prbs7_chk #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
`ifdef PRBS7_CHK_INV_EN
    input  logic             inv,
`endif
    output logic             lock,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_CNT_W = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_CNT_W = 8'(LOSS_CNT);

    state_t           state, state_nxt;
    logic [6:0]       sr, sr_nxt;
    logic [2:0]       fill, fill_nxt;
    logic [7:0]       match, match_nxt;
    logic [7:0]       miss, miss_nxt;
    logic             lock_nxt, err_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;

    logic             din_eff;
    logic             pred;
    logic             hit;
    logic             filled;
    logic [7:0]       match_inc;
    logic [7:0]       miss_inc;

`ifdef PRBS7_CHK_INV_EN
    assign din_eff = din ^ inv;
`else
    assign din_eff = din;
`endif

    assign pred      = ~(sr[6] ^ sr[5]);
    assign hit       = (din_eff == pred);
    assign filled    = (fill == 3'd7);
    assign match_inc = match + 8'd1;
    assign miss_inc  = miss + 8'd1;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= SEARCH;
            sr      <= 7'h00;
            fill    <= 3'd0;
            match   <= 8'd0;
            miss    <= 8'd0;
            lock    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees the pre-edge values.
            state   <= state_nxt;
            sr      <= sr_nxt;
            fill    <= fill_nxt;
            match   <= match_nxt;
            miss    <= miss_nxt;
            lock    <= lock_nxt;
            err     <= err_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
        state_nxt = state;
        sr_nxt    = sr;
        fill_nxt  = fill;
        match_nxt = match;
        miss_nxt  = miss;
        if (din_vld) begin
            case (state)
                SEARCH: begin
                    sr_nxt = {sr[5:0], din_eff};
                    if (!filled) begin
                        fill_nxt = fill + 3'd1;
                    end else if (sr == 7'h7F || !hit) begin
                        // All-ones is the XNOR lock-up state and must never count as a match.
                        match_nxt = 8'd0;
                    end else if (match_inc == LOCK_CNT_W) begin
                        state_nxt = LOCKED;
                        match_nxt = 8'd0;
                    end else begin
                        match_nxt = match_inc;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a line error is counted exactly once.
                    sr_nxt = {sr[5:0], pred};
                    if (hit) begin
                        miss_nxt = 8'd0;
                    end else if (miss_inc == LOSS_CNT_W) begin
                        state_nxt = SEARCH;
                        sr_nxt    = {sr[5:0], din_eff};
                        fill_nxt  = 3'd0;
                        match_nxt = 8'd0;
                        miss_nxt  = 8'd0;
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        lock_nxt    = (state_nxt == LOCKED);
        err_nxt     = din_vld && (state == LOCKED) && !hit;
        err_cnt_nxt = err_cnt;
        if (err_nxt && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs7_chk.sv
// Bench for prbs7_chk: table of stream phases plus hand-written reset/idle/inversion sequences,
// with a per-cycle scoreboard fed by a behavioural model; a second instance uses ERR_W=4.
module tb_prbs7_chk;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_vld = 1'b0;
    logic        inv = 1'b0;
    logic        lock, err, lock4, err4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;

    prbs7_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
        .ck(ck), .rst(rst), .din(din), .din_vld(din_vld),
`ifdef PRBS7_CHK_INV_EN
        .inv(inv),
`endif
        .lock(lock), .err(err), .err_cnt(err_cnt)
    );

    prbs7_chk #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(4)) dut4 (
        .ck(ck), .rst(rst), .din(din), .din_vld(din_vld),
`ifdef PRBS7_CHK_INV_EN
        .inv(inv),
`endif
        .lock(lock4), .err(err4), .err_cnt(err_cnt4)
    );

    always #5 ck = ~ck;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic lock;
        logic err;
        int   cnt;
        int   cnt4;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string name;
        bit    reset_first;
        int    n_bits;
        int    flip_start;
        int    flip_len;
        int    flip_every;
        bit    toggle;
        bit    ones;
        bit    exp_lock;
        int    exp_cnt;
        int    exp_pulses;
    } vec_t;
    vec_t tbl[$];

    // Reference generator and checker model.
    logic [6:0] g;
    bit         m_locked, m_lock, m_err;
    logic [6:0] m_sr;
    int         m_fill, m_match, m_miss, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic bit gen_next();
        bit b;
        b = ~(g[6] ^ g[5]);
        g = {g[5:0], b};
        return b;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_lock = 0; m_err = 0;
        m_sr = 7'h00; m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0;
        g = 7'h00;
    endtask

    task automatic model_step(input bit vld, input bit d_raw);
        bit d, p;
        logic [6:0] old;
        m_err = 0;
        if (vld) begin
            d   = d_raw ^ inv;
            old = m_sr;
            p   = ~(old[6] ^ old[5]);
            if (!m_locked) begin
                m_sr = {old[5:0], d};
                if (m_fill < 7) m_fill++;
                else begin
                    if (old == 7'h7F || d != p) m_match = 0;
                    else m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1;
                        m_match = 0;
                    end
                end
            end else begin
                m_sr = {old[5:0], p};
                if (d != p) begin
                    m_err = 1;
                    m_cnt++;
                    m_miss++;
                end else begin
                    m_miss = 0;
                end
                if (m_miss == LOSS_CNT) begin
                    m_locked = 0;
                    m_fill = 0; m_match = 0; m_miss = 0;
                    m_sr = {old[5:0], d};
                end
            end
        end
        m_lock = m_locked;
    endtask

    task automatic cycle(input bit vld, input bit d);
        exp_t e;
        din = d;
        din_vld = vld;
        model_step(vld, d);
        e.lock = m_lock;
        e.err  = m_err;
        e.cnt  = (m_cnt > 65535) ? 65535 : m_cnt;
        e.cnt4 = (m_cnt > 15) ? 15 : m_cnt;
        sb.push_back(e);
        @(posedge ck);
        #1;
        e = sb.pop_front();
        check("lock", 32'(lock), 32'(e.lock));
        check("err", 32'(err), 32'(e.err));
        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
        check("err_cnt4", 32'(err_cnt4), 32'(e.cnt4));
        if (err) pulse_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_vld = 1'b0;
        din = 1'b0;
        @(posedge ck);
        #1;
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err_cnt4", 32'(err_cnt4), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic void add(input string nm, input bit rf, input int n, input int fs, input int fl,
                                input int fe, input bit tg, input bit on, input bit el, input int ec,
                                input int ep);
        vec_t v;
        v.name = nm; v.reset_first = rf; v.n_bits = n; v.flip_start = fs; v.flip_len = fl;
        v.flip_every = fe; v.toggle = tg; v.ones = on; v.exp_lock = el; v.exp_cnt = ec;
        v.exp_pulses = ep;
        tbl.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v);
        bit b, flip;
        if (v.reset_first) do_reset();
        pulse_cnt = 0;
        for (int i = 0; i < v.n_bits; i++) begin
            b = v.ones ? 1'b1 : gen_next();
            flip = (i >= v.flip_start && i < v.flip_start + v.flip_len) ||
                   (v.flip_every != 0 && (i % v.flip_every) == v.flip_every - 1);
            cycle(1'b1, b ^ flip ^ inv);
            if (v.toggle) cycle(1'b0, 1'($urandom_range(0, 1)));
        end
        check({v.name, ".lock"}, 32'(lock), 32'(v.exp_lock));
        check({v.name, ".err_cnt"}, 32'(err_cnt), 32'(v.exp_cnt));
        check({v.name, ".err_cnt4"}, 32'(err_cnt4), 32'((v.exp_cnt > 15) ? 15 : v.exp_cnt));
        check({v.name, ".pulses"}, 32'(pulse_cnt), 32'(v.exp_pulses));
    endtask

    initial begin
        //  name        rst  n    fs fl every tog ones lock cnt pulses
        add("acq_22",    1,  22,  0, 0, 0,    0,  0,   0,   0,  0);
        add("acq_23",    0,  1,   0, 0, 0,    0,  0,   1,   0,  0);
        add("clean_50",  0,  50,  0, 0, 0,    0,  0,   1,   0,  0);
        add("flip_1",    0,  20,  5, 1, 0,    0,  0,   1,   1,  1);
        add("burst_3",   0,  10,  0, 3, 0,    0,  0,   1,   4,  3);
        add("reacq",     1,  23,  0, 0, 0,    0,  0,   1,   0,  0);
        add("burst_4",   0,  4,   0, 4, 0,    0,  0,   0,   4,  4);
        add("relock_22", 0,  22,  0, 0, 0,    0,  0,   0,   4,  0);
        add("relock_23", 0,  1,   0, 0, 0,    0,  0,   1,   4,  0);
        add("ones_200",  1,  200, 0, 0, 0,    0,  1,   0,   0,  0);
        add("acq_tog",   1,  23,  0, 0, 0,    1,  0,   1,   0,  0);
        add("iso_40",    0,  400, 0, 0, 10,   1,  0,   1,   40, 40);
        add("acq_9",     1,  23,  0, 0, 0,    0,  0,   1,   0,  0);
        add("nine",      0,  90,  0, 0, 10,   0,  0,   1,   9,  9);

        model_reset();
        repeat (2) @(posedge ck);
        #1;
        foreach (tbl[k]) run_vec(tbl[k]);

        // Asynchronous reset mid-cycle while locked with err_cnt=9: outputs clear before any edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst.lock", 32'(lock), 32'd0);
        check("async_rst.err_cnt", 32'(err_cnt), 32'd0);
        check("async_rst.err_cnt4", 32'(err_cnt4), 32'd0);
        @(posedge ck);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 22; i++) cycle(1'b1, gen_next());
        check("after_rst_22.lock", 32'(lock), 32'd0);
        cycle(1'b1, gen_next());
        check("after_rst_23.lock", 32'(lock), 32'd1);
        check("after_rst_23.err_cnt", 32'(err_cnt), 32'd0);

        // One error followed by idle cycles: err is a single pulse and everything holds.
        pulse_cnt = 0;
        cycle(1'b1, ~gen_next());
        check("idle_err.pulse", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("idle_hold.err", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, gen_next());
        check("idle_hold.err_cnt", 32'(err_cnt), 32'd1);
        check("idle_hold.pulses", 32'(pulse_cnt), 32'd1);
        check("idle_hold.lock", 32'(lock), 32'd1);

`ifdef PRBS7_CHK_INV_EN
        // Inverted stream with inv=1 locks cleanly.
        inv = 1'b1;
        do_reset();
        for (int i = 0; i < 23; i++) cycle(1'b1, ~gen_next());
        check("inv.lock", 32'(lock), 32'd1);
        check("inv.err_cnt", 32'(err_cnt), 32'd0);
        inv = 1'b0;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
